branch_target_buffer: RTL
=========================

Name: branch_target_buffer

Overview:
- Direct-mapped branch target buffer in the fetch stage, directly upstream of the decode-stage branch controller.
- Each cycle it predicts, from the fetch PC alone, whether the instruction is a taken control transfer and where it goes, so fetch can redirect a cycle before decode resolves it.
- Trained from the same EX-stage branch result used to train the direction predictor.
- Table state lives in RAM-style arrays with no reset. A sweep FSM initialises them after reset and on explicit flush.

Parameters:
- ADDR_WIDTH, 32, PC/target width; matches `ADDR_WIDTH.
- INDEX_BITS, 4, log2 of entry count (DEPTH = 2**INDEX_BITS = 16).
- CTR_INIT, 2'b01, counter value written on sweep (weakly not taken).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous reset, active low
- i_lookup_valid  in  1  fetch PC valid this cycle
- i_lookup_pc  in  ADDR_WIDTH  fetch PC
- o_hit  out  1  tag match on a valid entry
- o_pred_taken  out  1  hit and predicted taken
- o_pred_target  out  ADDR_WIDTH  stored target; don't-care when o_pred_taken=0
- i_upd_valid  in  1  EX branch/jump result valid
- i_upd_pc  in  ADDR_WIDTH  PC of resolved instruction
- i_upd_target  in  ADDR_WIDTH  resolved target address
- i_upd_outcome  in  BranchOutcome  TAKEN / NOT_TAKEN
- i_upd_is_jump  in  1  unconditional jump
- i_flush  in  1  invalidate all entries (context change)
- o_busy  out  1  sweep in progress; lookups miss, updates dropped

Behaviour:
- Address split:
  - index = pc[INDEX_BITS+1:2]; tag = pc[ADDR_WIDTH-1:INDEX_BITS+2].
  - pc[1:0] are ignored.
- Entry contents: valid, tag, target, 2-bit saturating counter, is_jump.
- Lookup (combinational, zero latency):
  - o_hit = i_lookup_valid & ~o_busy & valid[idx] & tag match.
  - o_pred_taken = o_hit & (is_jump | ctr[1]).
  - o_pred_target = target[idx].
  - When ~i_lookup_valid or o_busy: o_hit=0 and o_pred_taken=0.
- Update (posedge, only when i_upd_valid & ~o_busy):
  - Hit, conditional branch:
    - Counter saturates at 11 on TAKEN and at 00 on NOT_TAKEN.
    - On TAKEN the target is overwritten.
  - Hit, jump: counter set to 11, target overwritten.
  - Miss with TAKEN or jump: allocate, replacing any occupant.
    - valid=1, tag and target written, is_jump written.
    - Counter = 11 for a jump, 10 for a branch.
  - Miss with NOT_TAKEN conditional: no write.
- Same-cycle lookup and update to the same index: the lookup returns pre-update contents; no bypass.
- FSM states:
  - SWEEP: writes entry sweep_idx to valid=0, ctr=CTR_INIT. sweep_idx increments each cycle.
  - SWEEP → IDLE after writing entry DEPTH-1 (sweep_idx wraps to 0).
  - IDLE → SWEEP on i_flush, with sweep_idx=0.
- o_busy = (state==SWEEP).
- Reset:
  - While rst_n=0: state=SWEEP, sweep_idx=0, o_busy=1, o_hit=0, o_pred_taken=0.
  - After release, the sweep takes exactly DEPTH cycles. o_busy falls on the cycle after entry DEPTH-1 is written.
  - Reset asserted mid-sweep restarts the sweep from 0.
- i_flush while in SWEEP: restart at sweep_idx=0.
- i_flush in the same cycle as i_upd_valid: the update is dropped.
- Updates arriving while o_busy=1 are dropped silently. Under SIMULATION, emit stats_event("btb_upd_drop").
- SIMULATION stats per accepted lookup: "btb_lookup", plus "btb_hit" on a hit.

Decomposition:
- mips_core_pkg:
  - BranchOutcome (existing type, reused).
  - btb_entry_t struct {valid, tag, target, ctr[1:0], is_jump}.
  - btb_state_e {BTB_SWEEP, BTB_IDLE}.
- Sub-module: btb_sweep_fsm.
  - Contains state, sweep_idx, o_busy, the sweep write-enable and the sweep index.
  - The top module muxes the sweep write against the update write. The sweep has priority; the two are never concurrent because updates are gated by busy.

Test Plan:
- Reset for 2 cycles, release → o_busy=1 for exactly 16 cycles, then 0. A lookup at 0x0040_0000 during the sweep returns o_hit=0.
- Update pc=0x0040_0010 target=0x0040_0100 TAKEN, branch → next cycle, lookup 0x0040_0010 gives o_hit=1, o_pred_taken=1, o_pred_target=0x0040_0100.
- Same entry, two NOT_TAKEN updates (ctr 10→01→00) → o_hit=1, o_pred_taken=0. One TAKEN update (ctr 01) → still 0. A second TAKEN update → 1.
- Aliasing: allocate 0x0040_0010, then TAKEN update at 0x0040_0050 (same index 4) → lookup 0x0040_0010 misses and 0x0040_0050 hits. A NOT_TAKEN miss at 0x0040_0090 does not evict.
- Jump update pc=0x0040_0020 target=0x0040_0800 → lookup predicts taken. A same-cycle lookup of 0x0040_0020 during the update cycle shows o_hit=0.
- Assert i_flush with a simultaneous update → o_busy=1 for 16 cycles, the update is dropped, and all previously allocated PCs miss afterwards.

Source files
------------

// File: rtl/mips_core_pkg.sv
// Shared MIPS core types: branch outcome, BTB entry layout and sweep FSM states.
package mips_core_pkg;

  localparam int unsigned BTB_ADDR_WIDTH = 32;
  localparam int unsigned BTB_INDEX_BITS = 4;
  localparam int unsigned BTB_TAG_W      = BTB_ADDR_WIDTH - BTB_INDEX_BITS - 2;

  typedef enum logic {
    NOT_TAKEN = 1'b0,
    TAKEN     = 1'b1
  } BranchOutcome;

  typedef struct packed {
    logic                      valid;
    logic [BTB_TAG_W-1:0]      tag;
    logic [BTB_ADDR_WIDTH-1:0] target;
    logic [1:0]                ctr;
    logic                      is_jump;
  } btb_entry_t;

  typedef enum logic {
    BTB_SWEEP = 1'b0,
    BTB_IDLE  = 1'b1
  } btb_state_e;

endpackage

// File: rtl/btb_sweep_fsm.sv
// Walks every BTB entry after reset or flush so the table starts invalid.
module btb_sweep_fsm
  import mips_core_pkg::*;
#(
  parameter int unsigned INDEX_BITS = BTB_INDEX_BITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_flush,
  output logic                  o_busy,
  output logic                  o_sweep_we,
  output logic [INDEX_BITS-1:0] o_sweep_idx
);

  localparam int unsigned DEPTH = 1 << INDEX_BITS;

  btb_state_e            state_q;
  logic [INDEX_BITS-1:0] sweep_idx_q;

  // Sweep sequencer: one entry per cycle, flush or reset restarts from zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= BTB_SWEEP;
      sweep_idx_q <= '0;
    end else begin
      case (state_q)
        BTB_SWEEP: begin
          if (i_flush) begin
            sweep_idx_q <= '0;
          end else begin
            sweep_idx_q <= sweep_idx_q + 1'b1;
            if (sweep_idx_q == INDEX_BITS'(DEPTH - 1)) state_q <= BTB_IDLE;
          end
        end
        default: begin
          if (i_flush) begin
            state_q     <= BTB_SWEEP;
            sweep_idx_q <= '0;
          end
        end
      endcase
    end
  end

  assign o_busy      = (state_q == BTB_SWEEP);
  assign o_sweep_we  = (state_q == BTB_SWEEP);
  assign o_sweep_idx = sweep_idx_q;

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB: zero-latency lookup from fetch PC, trained from EX results.
module branch_target_buffer
  import mips_core_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = BTB_ADDR_WIDTH,
  parameter int unsigned INDEX_BITS = BTB_INDEX_BITS,
  parameter logic [1:0]  CTR_INIT   = 2'b01
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_lookup_valid,
  input  logic [ADDR_WIDTH-1:0] i_lookup_pc,
  output logic                  o_hit,
  output logic                  o_pred_taken,
  output logic [ADDR_WIDTH-1:0] o_pred_target,
  input  logic                  i_upd_valid,
  input  logic [ADDR_WIDTH-1:0] i_upd_pc,
  input  logic [ADDR_WIDTH-1:0] i_upd_target,
  input  BranchOutcome          i_upd_outcome,
  input  logic                  i_upd_is_jump,
  input  logic                  i_flush,
  output logic                  o_busy
);

  localparam int unsigned DEPTH = 1 << INDEX_BITS;

  // Entry layout is fixed by the package; refuse to build with other widths.
  if (ADDR_WIDTH != BTB_ADDR_WIDTH || INDEX_BITS != BTB_INDEX_BITS) begin : g_width_check
    $error("branch_target_buffer widths must match mips_core_pkg BTB widths");
  end

  btb_entry_t entries_q [DEPTH];

  logic                  sweep_we;
  logic [INDEX_BITS-1:0] sweep_idx;

  btb_sweep_fsm #(.INDEX_BITS(INDEX_BITS)) u_sweep (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_flush     (i_flush),
    .o_busy      (o_busy),
    .o_sweep_we  (sweep_we),
    .o_sweep_idx (sweep_idx)
  );

  logic [INDEX_BITS-1:0] lk_idx;
  btb_entry_t            lk_entry;

  // Lookup reads the pre-update entry; no bypass from a same-cycle write.
  always_comb begin
    lk_idx        = i_lookup_pc[INDEX_BITS+1:2];
    lk_entry      = entries_q[lk_idx];
    o_hit         = i_lookup_valid & ~o_busy & lk_entry.valid &
                    (lk_entry.tag == i_lookup_pc[ADDR_WIDTH-1:INDEX_BITS+2]);
    o_pred_taken  = o_hit & (lk_entry.is_jump | lk_entry.ctr[1]);
    o_pred_target = lk_entry.target;
  end

  logic [INDEX_BITS-1:0] upd_idx;
  btb_entry_t            upd_entry;
  btb_entry_t            upd_wdata;
  logic                  upd_hit;
  logic                  upd_taken;
  logic                  upd_accept;
  logic                  upd_we;

  // Training: counter/target update on hit, allocate on taken miss.
  always_comb begin
    upd_idx    = i_upd_pc[INDEX_BITS+1:2];
    upd_entry  = entries_q[upd_idx];
    upd_wdata  = upd_entry;
    upd_we     = 1'b0;
    upd_taken  = (i_upd_outcome == TAKEN);
    upd_hit    = upd_entry.valid &
                 (upd_entry.tag == i_upd_pc[ADDR_WIDTH-1:INDEX_BITS+2]);
    upd_accept = i_upd_valid & ~o_busy & ~i_flush;
    if (upd_accept) begin
      if (upd_hit) begin
        upd_we = 1'b1;
        if (i_upd_is_jump) begin
          upd_wdata.ctr     = 2'b11;
          upd_wdata.target  = i_upd_target;
          upd_wdata.is_jump = 1'b1;
        end else if (upd_taken) begin
          upd_wdata.ctr    = (upd_entry.ctr == 2'b11) ? 2'b11 : upd_entry.ctr + 2'd1;
          upd_wdata.target = i_upd_target;
        end else begin
          upd_wdata.ctr = (upd_entry.ctr == 2'b00) ? 2'b00 : upd_entry.ctr - 2'd1;
        end
      end else if (upd_taken || i_upd_is_jump) begin
        upd_we            = 1'b1;
        upd_wdata.valid   = 1'b1;
        upd_wdata.tag     = i_upd_pc[ADDR_WIDTH-1:INDEX_BITS+2];
        upd_wdata.target  = i_upd_target;
        upd_wdata.ctr     = i_upd_is_jump ? 2'b11 : 2'b10;
        upd_wdata.is_jump = i_upd_is_jump;
      end
    end
  end

  // Table write port: sweep has priority, updates are already gated by busy.
  always_ff @(posedge clk) begin
    if (sweep_we) begin
      entries_q[sweep_idx] <= '{valid: 1'b0, tag: '0, target: '0,
                                ctr: CTR_INIT, is_jump: 1'b0};
    end else if (upd_we) begin
      entries_q[upd_idx] <= upd_wdata;
    end
  end

endmodule
